// File: rtl/jelly_stream_crc_append.sv
// Byte-stream stage that forwards each frame unchanged and appends its reflected CRC (FCS),
// least-significant byte first, moving the end-of-frame marker onto the final FCS byte.
module jelly_stream_crc_append #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY       = 32'hEDB88320,
    parameter logic [CRC_WIDTH-1:0] INIT       = 32'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOROUT     = 32'hFFFFFFFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int FCS_BYTES = CRC_WIDTH / 8;
    localparam int CNT_W     = (FCS_BYTES > 1) ? $clog2(FCS_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FCS_BYTES - 1);

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_FCS  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CRC_WIDTH-1:0]    crc_q;
    logic [CRC_WIDTH-1:0]    crc_d;
    logic [CRC_WIDTH-1:0]    fcs_q;
    logic [CNT_W-1:0]        fcs_cnt_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    m_last_q;
    logic                    m_valid_q;
    logic [7:0]              fcs_byte_s;
    logic                    out_free_s;
    logic                    in_xfer_s;

    // One payload byte folded into the reflected CRC, one bit per iteration.
    function automatic logic [CRC_WIDTH-1:0] crc_next(input logic [CRC_WIDTH-1:0] crc,
                                                      input logic [7:0]           data);
        logic [CRC_WIDTH-1:0] c;
        c = crc ^ CRC_WIDTH'(data);
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Handshake qualifiers and datapath helpers.
    always_comb begin
        out_free_s = !m_valid_q || m_ready;
        s_ready    = (state_q == ST_PASS) && out_free_s;
        in_xfer_s  = cke && s_valid && s_ready;
        crc_d      = crc_next(crc_q, s_data);
        fcs_byte_s = fcs_q[{fcs_cnt_q, 3'b000} +: 8];
    end

    // Frame/FCS sequencer with the registered output stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_PASS;
            crc_q     <= INIT;
            fcs_q     <= {CRC_WIDTH{1'b0}};
            fcs_cnt_q <= {CNT_W{1'b0}};
            m_data_q  <= {DATA_WIDTH{1'b0}};
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else if (cke) begin
            case (state_q)
                ST_PASS: begin
                    if (in_xfer_s) begin
                        m_data_q  <= s_data;
                        m_last_q  <= 1'b0;
                        m_valid_q <= 1'b1;
                        if (s_last) begin
                            fcs_q     <= crc_d ^ XOROUT;
                            crc_q     <= INIT;
                            fcs_cnt_q <= {CNT_W{1'b0}};
                            state_q   <= ST_FCS;
                        end else begin
                            crc_q <= crc_d;
                        end
                    end else if (out_free_s) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                    end else begin
                        m_valid_q <= m_valid_q;
                    end
                end
                ST_FCS: begin
                    // The CRC register already holds INIT for the next frame here.
                    if (out_free_s) begin
                        m_data_q  <= DATA_WIDTH'(fcs_byte_s);
                        m_valid_q <= 1'b1;
                        m_last_q  <= (fcs_cnt_q == CNT_LAST);
                        if (fcs_cnt_q == CNT_LAST) begin
                            fcs_cnt_q <= {CNT_W{1'b0}};
                            state_q   <= ST_PASS;
                        end else begin
                            fcs_cnt_q <= fcs_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        m_valid_q <= m_valid_q;
                    end
                end
                default: begin
                    state_q   <= ST_PASS;
                    fcs_cnt_q <= {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

endmodule

// File: tb/tb_jelly_stream_crc_append.sv
// Self-checking bench: directed frames from the test plan plus random frames, checked
// cycle by cycle against a queue-based reference model of the expected output stream.
module tb_jelly_stream_crc_append;

    logic       clk;
    logic       reset_n;
    logic       cke;
    logic [7:0] s_data;
    logic       s_last;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;

    jelly_stream_crc_append dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cke     (cke),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       f;
    } ent_t;

    ent_t       exp_q[$];
    logic [7:0] frame_q[$];
    logic [8:0] got_q[$];
    int         got_cyc[$];
    logic [8:0] ref_q[$];

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   ready_mode = 0;
    int   cke_mode   = 0;
    bit   hold_v = 1'b0;
    logic [7:0] hold_d;
    logic       hold_l;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference CRC: whole frame fed bit by bit, LSB first, reflected polynomial.
    function automatic logic [31:0] frame_fcs();
        logic [31:0] crc;
        logic        fb;
        crc = 32'hFFFFFFFF;
        foreach (frame_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb  = crc[0] ^ frame_q[i][b];
                crc = crc >> 1;
                if (fb) crc = crc ^ 32'hEDB88320;
            end
        end
        return crc ^ 32'hFFFFFFFF;
    endfunction

    task automatic model_push(input logic [7:0] b, input logic l);
        logic [31:0] fcs;
        exp_q.push_back('{d: b, l: 1'b0, f: 1'b0});
        frame_q.push_back(b);
        if (l) begin
            fcs = frame_fcs();
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back('{d: fcs[8*k +: 8], l: (k == 3), f: 1'b1});
            end
            frame_q.delete();
        end
    endtask

    // Output handshake environment (owns m_ready and cke).
    initial begin
        m_ready = 1'b1;
        cke     = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode == 1) ? ($urandom % 2 == 0) : 1'b1;
            cke     = (cke_mode == 1) ? ($urandom % 8 != 0) : (cke_mode == 2) ? 1'b0 : 1'b1;
        end
    end

    // Monitor: s_ready rule, stall stability, and output stream against the model.
    always @(negedge clk) begin
        int pend;
        ent_t e;
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            pend = 0;
            foreach (exp_q[i]) if (exp_q[i].f) pend++;
            if (m_valid && exp_q.size() > 0 && exp_q[0].f) pend--;
            check_eq("s_ready", {31'd0, s_ready}, {31'd0, (pend == 0) && (!m_valid || m_ready)});
            if (hold_v) begin
                check_eq("stall_valid", {31'd0, m_valid}, 32'd1);
                check_eq("stall_data", {24'd0, m_data}, {24'd0, hold_d});
                check_eq("stall_last", {31'd0, m_last}, {31'd0, hold_l});
            end
            if (m_valid && m_ready && cke) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", {31'd0, m_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("out_data", {24'd0, m_data}, {24'd0, e.d});
                    check_eq("out_last", {31'd0, m_last}, {31'd0, e.l});
                    got_q.push_back({m_last, m_data});
                    got_cyc.push_back(cyc);
                end
            end
            hold_v = m_valid && !(m_ready && cke);
            hold_d = m_data;
            hold_l = m_last;
        end
        cyc++;
    end

    task automatic send_byte(input logic [7:0] b, input logic l);
        bit ok;
        s_data  = b;
        s_last  = l;
        s_valid = 1'b1;
        ok      = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            @(negedge clk);
            ok = s_ready && cke && reset_n;
            @(posedge clk);
            #1;
        end
        if (ok) model_push(b, l);
        else check_eq("accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_str(input int len);
        for (int i = 0; i < len; i++) send_byte(8'h31 + 8'(i), (i == len - 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", exp_q.size(), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_len"}, got_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
            check_eq(tag, {23'd0, got_q[i]}, {23'd0, ref_q[i]});
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_m_last", {31'd0, m_last}, 32'd0);
        check_eq("rst_m_data", {24'd0, m_data}, 32'd0);
        check_eq("rst_s_ready", {31'd0, s_ready}, 32'd1);
        reset_n = 1'b1;

        // "123456789" at full rate
        clear_logs();
        send_str(9);
        s_valid = 1'b0;
        wait_drain();
        ref_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
                  9'h026, 9'h039, 9'h0F4, 9'h1CB};
        check_log("crc_check_frame");
        if (got_cyc.size() == 13) check_eq("full_rate_span", got_cyc[12] - got_cyc[0], 32'd12);
        else check_eq("full_rate_count", got_cyc.size(), 32'd13);

        // single zero byte
        clear_logs();
        send_byte(8'h00, 1'b1);
        s_valid = 1'b0;
        wait_drain();
        ref_q = '{9'h000, 9'h08D, 9'h0EF, 9'h002, 9'h1D2};
        check_log("zero_frame");

        // random backpressure
        clear_logs();
        ready_mode = 1;
        send_str(9);
        s_valid = 1'b0;
        wait_drain();
        ready_mode = 0;
        ref_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
                  9'h026, 9'h039, 9'h0F4, 9'h1CB};
        check_log("stall_frame");

        // back-to-back frames, s_valid held
        repeat (2) @(posedge clk);
        #1;
        clear_logs();
        send_str(9);
        send_byte(8'h00, 1'b1);
        s_valid = 1'b0;
        wait_drain();
        ref_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
                  9'h026, 9'h039, 9'h0F4, 9'h1CB, 9'h000, 9'h08D, 9'h0EF, 9'h002, 9'h1D2};
        check_log("b2b");
        if (got_cyc.size() > 13) check_eq("b2b_gap", got_cyc[13] - got_cyc[12], 32'd1);
        else check_eq("b2b_count", got_cyc.size(), 32'd18);

        // reset mid-frame
        clear_logs();
        for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0);
        s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        exp_q.delete();
        frame_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_logs();
        send_byte(8'h00, 1'b1);
        s_valid = 1'b0;
        wait_drain();
        repeat (10) @(posedge clk);
        #1;
        ref_q = '{9'h000, 9'h08D, 9'h0EF, 9'h002, 9'h1D2};
        check_log("after_reset");

        // cke low for 3 cycles in the middle of the FCS
        clear_logs();
        send_str(9);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        cke_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        cke_mode = 0;
        wait_drain();
        ref_q = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037, 9'h038, 9'h039,
                  9'h026, 9'h039, 9'h0F4, 9'h1CB};
        check_log("cke_frame");

        // random frames, random backpressure, random clock enable, random idles
        ready_mode = 1;
        cke_mode   = 1;
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 16);
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), (i == len - 1));
                if ($urandom % 4 == 0) begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_valid = 1'b0;
        wait_drain();
        ready_mode = 0;
        cke_mode   = 0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
